// File: rtl/cd_sector_framer.sv
// cd_sector_framer: hunts for the CD sync pattern, frames raw sectors into a two-bank
// word buffer and splits CD-DA words into L/R samples. Optional macro: CDFR_DESCRAMBLE_EN.
module cd_sector_framer #(
  parameter int SECTOR_WORDS  = 1176,
  parameter int SYNC_MISS_MAX = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] CD_DATA,
  input  logic        CD_CK,
  input  logic        CD_AUDIO,
  output logic        BUF_WE,
  output logic [11:0] BUF_ADDR,
  output logic [15:0] BUF_DO,
  output logic        SECTOR_RDY,
  output logic        SECTOR_BANK,
  output logic [23:0] HDR_MSF,
  output logic [7:0]  HDR_MODE,
  output logic        LOCKED,
  output logic        SYNC_LOST,
  output logic [15:0] AUD_L,
  output logic [15:0] AUD_R,
  output logic        AUD_VALID
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [10:0] LAST_WORD = 11'(SECTOR_WORDS - 1);
  localparam logic [7:0]  MISS_MAX  = 8'(SYNC_MISS_MAX);

  function automatic logic [15:0] sync_word(input logic [2:0] idx);
    case (idx)
      3'd0:                   sync_word = 16'hFF00;
      3'd1, 3'd2, 3'd3, 3'd4: sync_word = 16'hFFFF;
      3'd5:                   sync_word = 16'h00FF;
      default:                sync_word = 16'h0000;
    endcase
  endfunction

  state_t      state_r;
  logic [2:0]  sync_idx_r;
  logic [10:0] cnt_r;
  logic        bank_r;
  logic [7:0]  miss_cnt_r;
  logic        miss_seen_r;
  logic        replay_act_r;
  logic [2:0]  replay_idx_r;
  logic        pend_v_r;
  logic [15:0] pend_data_r;
  logic        pend_audio_r;
  logic [7:0]  hdr_m_r;
  logic [7:0]  hdr_s_r;
  logic [7:0]  hdr_f_r;
  logic [7:0]  hdr_mode_r;
  logic        phase_r;
  logic [15:0] aud_l_hold_r;

  logic        proc_v_s;
  logic [15:0] proc_data_s;
  logic        proc_audio_s;
  logic [15:0] word_s;
  logic        sync_bad_s;
  logic [7:0]  miss_next_s;
  logic        miss_hit_s;

  // Select the strobe to act on: a strobe held back during sync replay goes first
  always_comb begin
    proc_v_s     = 1'b0;
    proc_data_s  = 16'h0000;
    proc_audio_s = 1'b0;
    if (replay_act_r) begin
      proc_v_s = 1'b0;
    end else if (pend_v_r) begin
      proc_v_s     = 1'b1;
      proc_data_s  = pend_data_r;
      proc_audio_s = pend_audio_r;
    end else begin
      proc_v_s     = CD_CK;
      proc_data_s  = CD_DATA;
      proc_audio_s = CD_AUDIO;
    end
  end

`ifdef CDFR_DESCRAMBLE_EN
  function automatic logic [30:0] lfsr_adv(input logic [14:0] seed);
    logic [14:0] r;
    logic [15:0] m;
    r = seed;
    m = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      m[i] = r[0];
      r    = {r[0] ^ r[1], r[14:1]};
    end
    return {r, m};
  endfunction

  logic [14:0] lfsr_r;
  logic [30:0] lfsr_adv_s;

  // Descramble payload words; the sync area passes through untouched
  always_comb begin
    lfsr_adv_s = lfsr_adv(lfsr_r);
    if (state_r == LOCK && cnt_r >= 11'd6) begin
      word_s = proc_data_s ^ lfsr_adv_s[15:0];
    end else begin
      word_s = proc_data_s;
    end
  end

  // Scrambler state: reseeded outside the payload so word 6 always starts at 0x0001
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lfsr_r <= 15'h0001;
    end else if (proc_v_s && !proc_audio_s) begin
      if (state_r == LOCK && cnt_r >= 11'd6 && cnt_r != LAST_WORD) begin
        lfsr_r <= lfsr_adv_s[30:16];
      end else begin
        lfsr_r <= 15'h0001;
      end
    end
  end
`else
  // Words pass through unmodified
  always_comb begin
    word_s = proc_data_s;
  end
`endif

  // Sync check inside a locked sector; the miss counter moves at most once per sector
  always_comb begin
    sync_bad_s  = 1'b0;
    miss_next_s = miss_cnt_r + 8'd1;
    if (cnt_r < 11'd6) begin
      sync_bad_s = (word_s != sync_word(cnt_r[2:0]));
    end else begin
      sync_bad_s = 1'b0;
    end
    miss_hit_s = sync_bad_s && !miss_seen_r && (miss_next_s >= MISS_MAX);
  end

  // Framer state machine with registered buffer, header and audio outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= HUNT;
      sync_idx_r   <= 3'd0;
      cnt_r        <= 11'd0;
      bank_r       <= 1'b0;
      miss_cnt_r   <= 8'd0;
      miss_seen_r  <= 1'b0;
      replay_act_r <= 1'b0;
      replay_idx_r <= 3'd0;
      pend_v_r     <= 1'b0;
      pend_data_r  <= 16'h0000;
      pend_audio_r <= 1'b0;
      hdr_m_r      <= 8'h00;
      hdr_s_r      <= 8'h00;
      hdr_f_r      <= 8'h00;
      hdr_mode_r   <= 8'h00;
      phase_r      <= 1'b0;
      aud_l_hold_r <= 16'h0000;
      BUF_WE       <= 1'b0;
      BUF_ADDR     <= 12'h000;
      BUF_DO       <= 16'h0000;
      SECTOR_RDY   <= 1'b0;
      SECTOR_BANK  <= 1'b0;
      HDR_MSF      <= 24'h000000;
      HDR_MODE     <= 8'h00;
      LOCKED       <= 1'b0;
      SYNC_LOST    <= 1'b0;
      AUD_L        <= 16'h0000;
      AUD_R        <= 16'h0000;
      AUD_VALID    <= 1'b0;
    end else begin
      BUF_WE     <= 1'b0;
      SECTOR_RDY <= 1'b0;
      SYNC_LOST  <= 1'b0;
      AUD_VALID  <= 1'b0;
      if (replay_act_r) begin
        BUF_WE       <= 1'b1;
        BUF_ADDR     <= {bank_r, 8'h00, replay_idx_r};
        BUF_DO       <= sync_word(replay_idx_r);
        replay_idx_r <= replay_idx_r + 3'd1;
        if (replay_idx_r == 3'd5) begin
          replay_act_r <= 1'b0;
        end
        if (CD_CK) begin
          pend_v_r     <= 1'b1;
          pend_data_r  <= CD_DATA;
          pend_audio_r <= CD_AUDIO;
        end
      end else begin
        pend_v_r <= 1'b0;
        if (proc_v_s && proc_audio_s) begin
          phase_r <= ~phase_r;
          if (!phase_r) begin
            aud_l_hold_r <= proc_data_s;
          end else begin
            AUD_L     <= aud_l_hold_r;
            AUD_R     <= proc_data_s;
            AUD_VALID <= 1'b1;
          end
          // Audio inside a data sector means the track changed under us
          if (state_r == LOCK && cnt_r != 11'd0) begin
            state_r    <= HUNT;
            LOCKED     <= 1'b0;
            SYNC_LOST  <= 1'b1;
            cnt_r      <= 11'd0;
            sync_idx_r <= 3'd0;
          end
        end else if (proc_v_s) begin
          phase_r <= 1'b0;
          if (state_r == HUNT) begin
            if (proc_data_s == sync_word(sync_idx_r)) begin
              if (sync_idx_r == 3'd5) begin
                state_r      <= LOCK;
                LOCKED       <= 1'b1;
                cnt_r        <= 11'd6;
                sync_idx_r   <= 3'd0;
                miss_cnt_r   <= 8'd0;
                miss_seen_r  <= 1'b0;
                replay_act_r <= 1'b1;
                replay_idx_r <= 3'd1;
                BUF_WE       <= 1'b1;
                BUF_ADDR     <= {bank_r, 11'd0};
                BUF_DO       <= 16'hFF00;
              end else begin
                sync_idx_r <= sync_idx_r + 3'd1;
              end
            end else begin
              sync_idx_r <= (proc_data_s == 16'hFF00) ? 3'd1 : 3'd0;
            end
          end else begin
            BUF_WE   <= 1'b1;
            BUF_ADDR <= {bank_r, cnt_r};
            BUF_DO   <= word_s;
            if (cnt_r == 11'd6) begin
              hdr_m_r <= word_s[7:0];
              hdr_s_r <= word_s[15:8];
            end
            if (cnt_r == 11'd7) begin
              hdr_f_r    <= word_s[7:0];
              hdr_mode_r <= word_s[15:8];
            end
            if (sync_bad_s && !miss_seen_r) begin
              miss_seen_r <= 1'b1;
              miss_cnt_r  <= miss_next_s;
            end
            if (cnt_r == 11'd5 && !sync_bad_s && !miss_seen_r) begin
              miss_cnt_r <= 8'd0;
            end
            if (miss_hit_s) begin
              state_r     <= HUNT;
              LOCKED      <= 1'b0;
              SYNC_LOST   <= 1'b1;
              cnt_r       <= 11'd0;
              sync_idx_r  <= 3'd0;
              miss_cnt_r  <= 8'd0;
              miss_seen_r <= 1'b0;
            end else if (cnt_r == LAST_WORD) begin
              SECTOR_RDY  <= 1'b1;
              SECTOR_BANK <= bank_r;
              bank_r      <= ~bank_r;
              cnt_r       <= 11'd0;
              miss_seen_r <= 1'b0;
              HDR_MSF     <= {hdr_m_r, hdr_s_r, hdr_f_r};
              HDR_MODE    <= hdr_mode_r;
            end else begin
              cnt_r <= cnt_r + 11'd1;
            end
          end
        end
      end
    end
  end

endmodule
